sprite_fetch_scheduler: RTL

- Per-scanline sequencer for the single shared sprite ROM port.
- During horizontal blanking it scans the sprite attribute table, picks the sprites that intersect the next scanline, and issues one ROM line read per hit sprite.
- It captures the fetched 8-pixel lines into a shadow slot buffer, then commits them atomically to the visible slot registers that the pixel renderer reads on the next line.

---
 rtl/sprite_fetch_scheduler.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/sprite_fetch_scheduler.sv
// Per-scanline sprite fetch sequencer: scans the attribute table, reads one ROM line
// per hit sprite into a shadow buffer, commits to visible slots. Optional: SPRITE_FETCH_STATS_EN.
module sprite_fetch_scheduler #(
  parameter int NUM_SPRITES  = 8,
  parameter int MAX_PER_LINE = 4,
  parameter int COORD_W      = 10
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  line_start,
  input  logic [COORD_W-1:0]                    next_line,
  input  logic [NUM_SPRITES*(7+2*COORD_W)-1:0]  sprite_table,
  output logic                                  rom_read_enable,
  output logic [3:0]                            rom_sprite_id,
  output logic [1:0]                            rom_orientation,
  output logic [2:0]                            rom_line_index,
  input  logic [7:0]                            rom_data,
  output logic [MAX_PER_LINE-1:0]               slot_valid,
  output logic [MAX_PER_LINE*8-1:0]             slot_bitmap,
  output logic [MAX_PER_LINE*COORD_W-1:0]       slot_x,
  output logic                                  fetch_done,
  output logic                                  busy,
  output logic                                  overflow
`ifdef SPRITE_FETCH_STATS_EN
  ,
  output logic [15:0]                           stat_drop_count
`endif
);

  localparam int EW = 7 + 2*COORD_W;
  localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int CW = $clog2(MAX_PER_LINE + 1);
  localparam logic [COORD_W:0] LINE_SPAN = 8;

  typedef enum logic [1:0] {IDLE, SCAN, WAIT} state_t;

  state_t               state, state_next;
  logic [IW-1:0]        idx;
  logic [COORD_W-1:0]   line_q;
  logic [CW-1:0]        shadow_count;
  logic                 shadow_ovf;
  logic [MAX_PER_LINE-1:0] shadow_valid;
  logic [7:0]           shadow_bitmap [MAX_PER_LINE];
  logic [COORD_W-1:0]   shadow_x      [MAX_PER_LINE];

  logic [EW-1:0]        entry;
  logic                 ent_en;
  logic [3:0]           ent_id;
  logic [1:0]           ent_orient;
  logic [COORD_W-1:0]   ent_x, ent_y;
  logic [COORD_W:0]     diff;
  logic                 hit, room, last;
  logic                 issue, capture, advance, commit, set_ovf, abort;

  always_comb begin
    entry = '0;
    for (int unsigned s = 0; s < NUM_SPRITES; s++) begin
      if (idx == IW'(s)) entry = sprite_table[s*EW +: EW];
    end
  end

  assign ent_en     = entry[EW-1];
  assign ent_id     = entry[EW-2 -: 4];
  assign ent_orient = entry[2*COORD_W+1 -: 2];
  assign ent_x      = entry[2*COORD_W-1 -: COORD_W];
  assign ent_y      = entry[COORD_W-1:0];

  // One extra bit so y > line shows up as a borrow instead of wrapping into range.
  assign diff = {1'b0, line_q} - {1'b0, ent_y};
  assign hit  = ent_en && !diff[COORD_W] && (diff < LINE_SPAN);
  assign room = shadow_count < CW'(MAX_PER_LINE);
  assign last = idx == IW'(NUM_SPRITES - 1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    commit     = 1'b0;
    set_ovf    = 1'b0;
    abort      = 1'b0;
    if (line_start) begin
      state_next = SCAN;
      abort      = (state != IDLE);
    end else begin
      case (state)
        SCAN: begin
          if (hit && room) begin
            issue      = 1'b1;
            state_next = WAIT;
          end else begin
            set_ovf = hit;
            if (last) begin
              commit     = 1'b1;
              state_next = IDLE;
            end else begin
              advance = 1'b1;
            end
          end
        end
        WAIT: begin
          capture = 1'b1;
          if (last) begin
            commit     = 1'b1;
            state_next = IDLE;
          end else begin
            advance    = 1'b1;
            state_next = SCAN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx             <= '0;
      line_q          <= '0;
      shadow_count    <= '0;
      shadow_ovf      <= 1'b0;
      shadow_valid    <= '0;
      for (int unsigned k = 0; k < MAX_PER_LINE; k++) begin
        shadow_bitmap[k] <= '0;
        shadow_x[k]      <= '0;
      end
      rom_read_enable <= 1'b0;
      rom_sprite_id   <= '0;
      rom_orientation <= '0;
      rom_line_index  <= '0;
      slot_valid      <= '0;
      slot_bitmap     <= '0;
      slot_x          <= '0;
      fetch_done      <= 1'b0;
      busy            <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      fetch_done <= commit;
      busy       <= (state_next != IDLE);
      if (line_start) begin
        line_q          <= next_line;
        idx             <= '0;
        shadow_count    <= '0;
        shadow_ovf      <= 1'b0;
        shadow_valid    <= '0;
        rom_read_enable <= 1'b0;
      end else begin
        if (advance) idx <= idx + 1'b1;
        if (set_ovf) shadow_ovf <= 1'b1;
        if (issue) begin
          rom_read_enable <= 1'b1;
          rom_sprite_id   <= ent_id;
          rom_orientation <= ent_orient;
          rom_line_index  <= diff[2:0];
        end
        if (capture) begin
          for (int unsigned k = 0; k < MAX_PER_LINE; k++) begin
            if (CW'(k) == shadow_count) begin
              shadow_bitmap[k] <= ~rom_data;
              shadow_x[k]      <= ent_x;
              shadow_valid[k]  <= 1'b1;
            end
          end
          shadow_count    <= shadow_count + 1'b1;
          rom_read_enable <= 1'b0;
        end
        // A commit out of WAIT also folds in the line being captured this same edge.
        if (commit) begin
          overflow <= shadow_ovf | set_ovf;
          for (int unsigned k = 0; k < MAX_PER_LINE; k++) begin
            if (capture && (CW'(k) == shadow_count)) begin
              slot_valid[k]                  <= 1'b1;
              slot_bitmap[k*8 +: 8]          <= ~rom_data;
              slot_x[k*COORD_W +: COORD_W]   <= ent_x;
            end else if (CW'(k) < shadow_count) begin
              slot_valid[k]                  <= shadow_valid[k];
              slot_bitmap[k*8 +: 8]          <= shadow_bitmap[k];
              slot_x[k*COORD_W +: COORD_W]   <= shadow_x[k];
            end else begin
              slot_valid[k]                  <= 1'b0;
              slot_bitmap[k*8 +: 8]          <= '0;
              slot_x[k*COORD_W +: COORD_W]   <= '0;
            end
          end
        end
      end
    end
  end

`ifdef SPRITE_FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_drop_count <= '0;
    end else if ((abort || (commit && (shadow_ovf || set_ovf))) && (stat_drop_count != 16'hFFFF)) begin
      stat_drop_count <= stat_drop_count + 1'b1;
    end
  end
`endif

endmodule
